// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch stage and the decoder.
//   - fetch FSM state encoding (BOOT/RUN/HALT)
//   - instruction width and the NOP encoding used for bubbles
//   - redirect-source select encoding
//   - opcode/funct constants reused by the decoder
//   - branch target helper
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JUMP = 2'd2,
    SEL_JR   = 2'd3
  } redir_sel_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  // Branch target: PC+4 plus the sign-extended word offset, wrapping mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                 input logic [15:0] offset);
    return pc4 + {{14{offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC selection for the fetch stage.
// Picks the candidate PC (jr > jump > branch > sequential) and flags it as
// faulty when it is misaligned or beyond the end of instruction memory.
// Ports:
//   pc_i          current PC
//   br_taken_i, br_pc4_i, br_offset_i   conditional branch redirect
//   jump_en_i, jump_index_i             J/JAL redirect
//   jr_en_i, jr_target_i                JR redirect
//   redirect_o    any redirect source is active
//   target_o      selected next PC (sequential PC+4 when no redirect)
//   seq_pc4_o     PC+4 of the current PC
//   fault_o       target_o is not a legal fetch address
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024
) (
  input  logic [31:0] pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_pc4_i,
  input  logic [15:0] br_offset_i,
  input  logic        jump_en_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_en_i,
  input  logic [31:0] jr_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic [31:0] seq_pc4_o,
  output logic        fault_o
);

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  redir_sel_e sel_s;

  // Source priority and target mux.
  always_comb begin
    sel_s      = SEL_SEQ;
    seq_pc4_o  = pc_i + 32'd4;
    target_o   = seq_pc4_o;
    if (jr_en_i) begin
      sel_s = SEL_JR;
    end else if (jump_en_i) begin
      sel_s = SEL_JUMP;
    end else if (br_taken_i) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_SEQ;
    end
    case (sel_s)
      SEL_JR:   target_o = jr_target_i;
      SEL_JUMP: target_o = {br_pc4_i[31:28], jump_index_i, 2'b00};
      SEL_BR:   target_o = branch_target(br_pc4_i, br_offset_i);
      SEL_SEQ:  target_o = seq_pc4_o;
      default:  target_o = seq_pc4_o;
    endcase
    redirect_o = (sel_s != SEL_SEQ);
  end

  // Legal fetch address: word aligned and word index inside the memory.
  always_comb begin
    fault_o = (target_o[1:0] != 2'b00) || ({2'b00, target_o[31:2]} >= DEPTH_W);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage. Owns the PC, drives the
// instruction-memory word address and captures fetched words into IF/ID.
// Optional build macro: BRANCH_DELAY_SLOT_EN -- when defined, the word in
// flight during a redirect is kept as a delay-slot instruction instead of
// being flushed, and redirects wait until stall is low.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   stall, halt_req            pipeline hold / stop request
//   br_*, jump_*, jr_*         redirect requests from downstream
//   imem_addr, imem_instr      instruction memory address / returned word
//   if_id_valid/pc4/instr      IF/ID pipeline register
//   halted, pc_fault           HALT state and fault cause
//   fetch_count                instructions captured into IF/ID
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                br_taken,
  input  logic [31:0]         br_pc4,
  input  logic [15:0]         br_offset,
  input  logic                jump_en,
  input  logic [25:0]         jump_index,
  input  logic                jr_en,
  input  logic [31:0]         jr_target,
  output logic [31:0]         imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  output logic                if_id_valid,
  output logic [31:0]         if_id_pc4,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic                halted,
  output logic                pc_fault,
  output logic [31:0]         fetch_count
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  fetch_state_e        state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [31:0]         pc4_q, pc4_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                fault_q, fault_d;
  logic [31:0]         count_q, count_d;

  logic                redirect_s;
  logic [31:0]         target_s;
  logic [31:0]         seq_pc4_s;
  logic                tgt_fault_s;
  logic                advance_s;

  next_pc_sel #(.IMEM_DEPTH(IMEM_DEPTH)) u_next_pc_sel (
    .pc_i         (pc_q),
    .br_taken_i   (br_taken),
    .br_pc4_i     (br_pc4),
    .br_offset_i  (br_offset),
    .jump_en_i    (jump_en),
    .jump_index_i (jump_index),
    .jr_en_i      (jr_en),
    .jr_target_i  (jr_target),
    .redirect_o   (redirect_s),
    .target_o     (target_s),
    .seq_pc4_o    (seq_pc4_s),
    .fault_o      (tgt_fault_s)
  );

  // Fetch FSM next state, PC, IF/ID and counter.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    pc4_d     = pc4_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    count_d   = count_q;
    // Without delay slots a redirect squashes the stall; with them the
    // redirect is held upstream until the stall clears.
    advance_s = DELAY_SLOT ? !stall : (redirect_s || !stall);
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
          pc4_d   = 32'h0000_0000;
          instr_d = NOP;
        end else if (!advance_s) begin
          state_d = ST_RUN;
        end else if (tgt_fault_s) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
          valid_d = 1'b0;
          pc4_d   = 32'h0000_0000;
          instr_d = NOP;
        end else begin
          pc_d = target_s;
          if (redirect_s && !DELAY_SLOT) begin
            valid_d = 1'b0;
            pc4_d   = 32'h0000_0000;
            instr_d = NOP;
          end else begin
            valid_d = 1'b1;
            pc4_d   = seq_pc4_s;
            instr_d = imem_instr;
            count_d = count_q + 32'd1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
        pc4_d   = 32'h0000_0000;
        instr_d = NOP;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      pc4_q   <= 32'h0000_0000;
      instr_q <= NOP;
      fault_q <= 1'b0;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;
  assign halted      = (state_q == ST_HALT);
  assign pc_fault    = fault_q;
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the memory's word address.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Captures the returned instruction word into the IF/ID pipeline register, with stall, flush and halt control, for the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_DEPTH, 1024, number of 32-bit words in instruction memory; PC word index must be < IMEM_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; holds PC and IF/ID.
- halt_req  in  1  control request to stop fetching.
- br_taken  in  1  taken conditional branch, resolved downstream.
- br_pc4  in  32  PC+4 of the redirecting instruction.
- br_offset  in  16  branch immediate, sign-extended and shifted left by 2.
- jump_en  in  1  J/JAL redirect.
- jump_index  in  26  jump target index.
- jr_en  in  1  JR redirect.
- jr_target  in  32  register jump target.
- imem_addr  out  32  byte address to instruction memory; equals the PC register.
- imem_instr  in  32  instruction word, combinational from memory.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc4  out  32  PC+4 of the instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID; 0 (NOP) when invalid.
- halted  out  1  unit in HALT state.
- pc_fault  out  1  halt was caused by a bad target.
- fetch_count  out  32  number of instructions captured into IF/ID.

Behaviour:
- Reset (synchronous, wins over everything):
  - pc=RESET_PC; all IF/ID outputs 0; halted=0; pc_fault=0; fetch_count=0; state=BOOT.
  - Applies from any state, including mid-stall or in HALT.
- State BOOT:
  - One cycle; no capture, PC unchanged, if_id_valid=0; next state RUN.
  - Gives the memory a settle cycle after init.
- State RUN, evaluated each cycle in priority order: halt_req > redirect > stall > sequential.
- halt_req=1:
  - Go to HALT; IF/ID loads a bubble (valid=0, instr=0); PC frozen.
- Redirect (any of jr_en, jump_en, br_taken); source priority jr_en > jump_en > br_taken:
  - jr target = jr_target.
  - jump target = {br_pc4[31:28], jump_index, 2'b00}.
  - branch target = br_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00}, modulo 2^32.
  - PC loads the target; IF/ID loads a bubble (flush); fetch_count unchanged.
  - Redirect overrides stall.
- stall=1, no redirect:
  - PC, IF/ID and fetch_count all hold.
- Sequential:
  - if_id_instr<=imem_instr; if_id_pc4<=pc+4; if_id_valid<=1; pc<=pc+4; fetch_count<=fetch_count+1.
  - PC+4 wraps modulo 2^32.
- Target check, applied to every PC load (sequential or redirect):
  - Fault if target[1:0]!=0 or target[31:2]>=IMEM_DEPTH.
  - On fault: PC not updated; state=HALT; pc_fault=1; IF/ID loads a bubble.
  - Sequential overflow is a fault: PC at the last word, then PC+4 faults.
- State HALT:
  - halted=1; PC and fetch_count frozen; IF/ID stays a bubble.
  - All inputs ignored until reset.

Optional Feature:
- Macro BRANCH_DELAY_SLOT_EN.
- Defined:
  - On redirect, IF/ID captures the current imem_instr as a normal fetch (delay slot, valid=1, fetch_count increments) while PC loads the target.
  - Redirects are acted on only when stall=0; upstream holds redirect inputs through a stall.
- Undefined: flush semantics as described in Behaviour.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding (BOOT/RUN/HALT);
  - INSTR_W=32;
  - NOP constant 32'h0;
  - redirect-select encoding;
  - opcode constants reused by the decoder.
- One natural sub-module: next_pc_sel.
  - Combinational target computation and priority select, plus the alignment/range fault check.
  - The top keeps the PC register, IF/ID register, FSM and counter.

Test Plan:
- Reset, then 4 unstalled cycles with memory words 0..3 = A,B,C,D -> cycle 1 BOOT (valid=0); then IF/ID shows A (pc4=4), B (pc4=8), C; imem_addr 0,4,8,12; fetch_count=3.
- stall held 2 cycles after B is captured -> imem_addr=8, IF/ID=B and fetch_count hold; release -> C is captured.
- br_taken with br_pc4=0x10, br_offset=0xFFFE -> PC=0x08; next IF/ID valid=0, instr=0. With BRANCH_DELAY_SLOT_EN: slot instruction valid, count+1.
- jr_en=1 and jump_en=1 together, jr_target=0x20 -> PC=0x20 (jr wins); jr_target=0x22 -> pc_fault=1, halted=1, PC unchanged.
- PC at word 1023 with IMEM_DEPTH=1024, sequential step -> fault/HALT; then reset -> PC=RESET_PC, BOOT, pc_fault=0.
- halt_req concurrent with br_taken and stall -> HALT entered, PC frozen, later redirects ignored.
